// File: rtl/vga_scanout_stream.sv
// Raster-order framebuffer scanout: strip-memory reads, latency pipe, credit-limited FIFO, Avalon-ST source.
// Define VGA_SCANOUT_TESTPAT_EN to add a testpat input selecting 8 vertical colour bars (requires H_RES >= 8).
module vga_scanout_stream #(
    parameter int H_RES         = 800,
    parameter int V_RES         = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32,
    parameter int CHAN_W        = 5,
    parameter int OUT_CHAN_W    = 10,
    parameter int RD_LATENCY    = 1,
    parameter int FIFO_DEPTH_W  = 3
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  enable,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic                                                  testpat,
`endif
    output logic                                                  rd_en,
    output logic [BUFFER_ADDR_W-1:0]                              raddress,
    output logic [((CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1)-1:0] rselect,
    input  logic [3*CHAN_W-1:0]                                   rdata,
    output logic [3*OUT_CHAN_W-1:0]                               m_data,
    output logic                                                  m_startofpacket,
    output logic                                                  m_endofpacket,
    output logic                                                  m_valid,
    input  logic                                                  m_ready,
    output logic                                                  frame_done,
    output logic                                                  busy
);

    localparam int STRIP = V_RES / CORES_COUNT;
    localparam int X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int LY_W  = (STRIP > 1) ? $clog2(STRIP) : 1;
    localparam int SEL_W = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
    localparam int PIX_W = 3 * CHAN_W;
    localparam int ENT_W = PIX_W + 2;
    localparam int DEPTH = 1 << FIFO_DEPTH_W;
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_RES - 1);
    localparam logic [LY_W-1:0]  LY_LAST  = LY_W'(STRIP - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(CORES_COUNT - 1);

    // Source MSBs repeated into the low bits so full scale stays full scale.
    function automatic logic [OUT_CHAN_W-1:0] expand_chan(input logic [CHAN_W-1:0] c);
        logic [OUT_CHAN_W-1:0] r;
        r = '0;
        for (int i = 0; i < OUT_CHAN_W; i++)
            r[OUT_CHAN_W-1-i] = c[CHAN_W-1-(i % CHAN_W)];
        return r;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [X_W-1:0]          x_q;
    logic [LY_W-1:0]         ly_q;
    logic [SEL_W-1:0]        sel_q;
    logic [BUFFER_ADDR_W-1:0] addr_q;
    logic [RD_LATENCY-1:0]   vld_p, sop_p, eop_p;
    logic [ENT_W-1:0]        fifo_mem [DEPTH];
    logic [FIFO_DEPTH_W:0]   wr_ptr_q, rd_ptr_q, fifo_count;
    logic [ENT_W-1:0]        head;
    logic [PIX_W-1:0]        push_pix;
    logic                    push, pop, eop_pop, frame_start, first_pix, last_pix;
    int                      outstanding;

    always_comb begin
        outstanding = 0;
        for (int i = 0; i < RD_LATENCY; i++)
            outstanding = outstanding + int'(vld_p[i]);
    end

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign first_pix  = (x_q == '0) && (ly_q == '0) && (sel_q == '0);
    assign last_pix   = (x_q == X_LAST) && (ly_q == LY_LAST) && (sel_q == SEL_LAST);
    assign rd_en      = (state_q == S_RUN) && ((outstanding + int'(fifo_count)) < DEPTH);
    assign raddress   = addr_q;
    assign rselect    = sel_q;
    assign pop        = m_valid && m_ready;
    assign eop_pop    = pop && head[PIX_W+1];
    assign busy       = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d     = S_RUN;
                    frame_start = 1'b1;
                end
            end
            S_RUN: begin
                if (rd_en && last_pix) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (eop_pop) begin
                    state_d     = enable ? S_RUN : S_IDLE;
                    frame_start = enable;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Raster position: strip address is a running counter restarted at each strip change.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            ly_q   <= '0;
            sel_q  <= '0;
            addr_q <= '0;
        end else if (rd_en) begin
            if (x_q == X_LAST) begin
                x_q <= '0;
                if (ly_q == LY_LAST) begin
                    ly_q   <= '0;
                    addr_q <= '0;
                    sel_q  <= (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
                end else begin
                    ly_q   <= ly_q + 1'b1;
                    addr_q <= addr_q + 1'b1;
                end
            end else begin
                x_q    <= x_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    // Read-latency pipe stage boundary: tags travel with each outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= rd_en;
            for (int i = 1; i < RD_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        sop_p[0] <= first_pix;
        eop_p[0] <= last_pix;
        for (int i = 1; i < RD_LATENCY; i++) begin
            sop_p[i] <= sop_p[i-1];
            eop_p[i] <= eop_p[i-1];
        end
    end

    assign push = vld_p[RD_LATENCY-1];

`ifdef VGA_SCANOUT_TESTPAT_EN
    localparam int REM_W = X_W + 4;

    // Bar index bits map to channel enables: R = ~b[1], G = ~b[2], B = ~b[0].
    function automatic logic [PIX_W-1:0] bar_pix(input logic [2:0] b);
        return {{CHAN_W{~b[1]}}, {CHAN_W{~b[2]}}, {CHAN_W{~b[0]}}};
    endfunction

    logic             tp_q;
    logic [2:0]       bar_q;
    logic [REM_W-1:0] bar_rem_q, bar_rem_inc;
    logic [2:0]       bar_p [RD_LATENCY];

    // bar_q tracks floor(x*8/H_RES) via a remainder accumulator instead of a divider.
    assign bar_rem_inc = bar_rem_q + REM_W'(8);

    always_ff @(posedge clk) begin
        if (rst) begin
            tp_q      <= 1'b0;
            bar_q     <= '0;
            bar_rem_q <= '0;
        end else begin
            if (frame_start) tp_q <= testpat;
            if (rd_en) begin
                if (x_q == X_LAST) begin
                    bar_q     <= '0;
                    bar_rem_q <= '0;
                end else if (bar_rem_inc >= REM_W'(H_RES)) begin
                    bar_q     <= bar_q + 1'b1;
                    bar_rem_q <= bar_rem_inc - REM_W'(H_RES);
                end else begin
                    bar_rem_q <= bar_rem_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        bar_p[0] <= bar_q;
        for (int i = 1; i < RD_LATENCY; i++) bar_p[i] <= bar_p[i-1];
    end

    assign push_pix = tp_q ? bar_pix(bar_p[RD_LATENCY-1]) : rdata;
`else
    assign push_pix = rdata;
`endif

    // FIFO write stage boundary: credit check upstream guarantees a free slot on push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[FIFO_DEPTH_W-1:0]] <= {eop_p[RD_LATENCY-1], sop_p[RD_LATENCY-1], push_pix};
    end

    always_ff @(posedge clk) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= eop_pop;
    end

    // Output stage: FIFO head drives the stream, held while the sink stalls.
    assign head            = fifo_mem[rd_ptr_q[FIFO_DEPTH_W-1:0]];
    assign m_valid         = (fifo_count != '0);
    assign m_startofpacket = m_valid && head[PIX_W];
    assign m_endofpacket   = m_valid && head[PIX_W+1];
    assign m_data          = {expand_chan(head[3*CHAN_W-1:2*CHAN_W]),
                              expand_chan(head[2*CHAN_W-1:CHAN_W]),
                              expand_chan(head[CHAN_W-1:0])};

endmodule

// File: doc/vga_scanout_stream.md
Name: vga_scanout_stream

Overview:
- Single-clock framebuffer scanout engine, next generation of the VGA stream master.
- Walks the screen in raster order and issues reads to the per-core strip memories (one strip of V_RES/CORES_COUNT lines per core).
- Absorbs a configurable memory read latency and expands packed colour to the video pipeline's channel width.
- Drives an Avalon-ST source with correct ready/valid backpressure, sized by a credit-limited internal FIFO; sits between the PPU memories and the VGA controller.

Parameters:
- H_RES, 800, active pixels per line.
- V_RES, 600, active lines per frame; must be divisible by CORES_COUNT.
- CORES_COUNT, 10, number of PPU strip memories.
- BUFFER_ADDR_W, 32, width of raddress.
- CHAN_W, 5, bits per colour channel in memory (rdata = 3*CHAN_W).
- OUT_CHAN_W, 10, bits per channel on m_data; must be >= CHAN_W.
- RD_LATENCY, 1, cycles from rd_en to valid rdata (>= 1).
- FIFO_DEPTH_W, 3, log2 of internal FIFO depth; depth must be >= RD_LATENCY+1.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled at frame boundaries.
- rd_en  out  1  read strobe to the selected strip memory.
- raddress  out  BUFFER_ADDR_W  word address within the strip.
- rselect  out  max(1,$clog2(CORES_COUNT))  strip/core index.
- rdata  in  3*CHAN_W  read data, valid RD_LATENCY cycles after rd_en.
- m_data  out  3*OUT_CHAN_W  pixel: R at top field, G middle, B bottom.
- m_startofpacket  out  1  first pixel of frame.
- m_endofpacket  out  1  last pixel of frame.
- m_valid  out  1  beat valid.
- m_ready  in  1  sink ready, ready latency 0.
- frame_done  out  1  one-cycle pulse when the eop beat is accepted.
- busy  out  1  high from frame start until the eop beat is accepted.

Behaviour:
- Reset (rst high at posedge): all counters, FIFO and latency pipe are cleared.
  - rd_en=0, raddress=0, rselect=0, m_valid=0, sop=eop=0, frame_done=0, busy=0.
  - Any in-flight reads are discarded.
- State machine:
  - IDLE: enter RUN when enable=1; asserts busy.
  - RUN: issue reads. After the last read of the frame (x=H_RES-1, y=V_RES-1) issued, go to DRAIN.
  - DRAIN: on eop beat acceptance, pulse frame_done. If enable=1 that cycle go to RUN (new frame, no idle gap required), else go to IDLE.
- Read issue: rd_en=1 in RUN iff (outstanding + fifo_count) < 2**FIFO_DEPTH_W.
  - outstanding = reads in flight in the RD_LATENCY pipe. This guarantees the FIFO never overflows.
  - Simultaneous FIFO pop in the same cycle counts as freeing a slot only from the next cycle.
- Addressing: per issued read, x increments. At x=H_RES-1, x wraps to 0 and y increments.
  - Strip line ly wraps at V_RES/CORES_COUNT-1, and rselect then increments, wrapping to 0 after CORES_COUNT-1.
  - raddress = ly*H_RES + x, maintained as an incrementing counter reset to 0 at each strip change; no multiplier.
- The latency pipe carries valid, sop (x=0,y=0) and eop (last pixel) tags alongside each read; rdata is captured into the FIFO with its tags exactly RD_LATENCY cycles after rd_en.
- Output:
  - m_valid = FIFO not empty; head entry drives m_data/sop/eop.
  - Pop on m_valid && m_ready. m_data/sop/eop are held stable while m_valid && !m_ready.
- Colour expansion: each CHAN_W field is placed in the MSBs of its OUT_CHAN_W field.
  - Remaining LSBs are filled by repeating the source MSBs, so full-scale maps to full-scale: 5'h1F -> 10'h3FF, 5'h10 -> 10'h210.
  - rdata[CHAN_W-1:0] is blue, rdata[3*CHAN_W-1:2*CHAN_W] is red.
- enable falling mid-frame: the frame completes fully (all H_RES*V_RES beats), then IDLE. enable rising mid-frame has no effect.
- Every frame contains exactly H_RES*V_RES beats, with sop only on the first and eop only on the last.

Optional Feature:
- Macro VGA_SCANOUT_TESTPAT_EN.
- Defined:
  - Adds input testpat (1 bit, sampled with enable at frame start, held for the whole frame).
  - When latched high, FIFO write data is replaced by 8 vertical colour bars. The bar index is x*8/H_RES, computed from a counter.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black, each channel all-ones or zero.
  - rd_en timing and addressing are unchanged.
- Not defined: no testpat port; data always comes from rdata.

Test Plan:
- Addressing: H_RES=4, V_RES=4, CORES_COUNT=2, RD_LATENCY=2, FIFO_DEPTH_W=2, m_ready=1, enable=1 -> rd_en issues (rselect,raddress) = (0,0..7) then (1,0..7); 16 beats; sop on beat 0, eop on beat 15; frame_done one cycle after beat 15 handshake; the next frame starts immediately.
- Backpressure: same params, m_ready=0 for 20 cycles mid-frame -> rd_en drops once outstanding+fifo_count=4; m_data stable; after release all 16 distinct rdata values arrive in order with none lost or duplicated.
- Colour expansion: CHAN_W=5, OUT_CHAN_W=10, rdata=15'h7C00 -> m_data=30'h3FF00000; rdata=15'h4210 -> m_data=30'h21084210.
- Enable drop: enable deasserted at beat 5 -> frame still completes 16 beats with eop, frame_done pulses, then m_valid=0, rd_en=0, busy=0.
- Reset mid-frame at beat 9 with 2 reads in flight -> all outputs at reset values next cycle; the late rdata is not pushed; after rst low and enable=1 the first beat has sop=1 and comes from raddress 0, rselect 0.
- VGA_SCANOUT_TESTPAT_EN with testpat=1, H_RES=8 -> beats 0..7 of each line are FFFFFFFF-style bars in order: 30'h3FFFFFFF, 30'h3FFFFC00, ..., final beat 30'h0.
